// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: mode encodings and the
// one-position rotate used by the chase mode.
package led_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    // Widest LED bank rot1 can handle; callers pass their real width.
    localparam int unsigned LED_MAX_W = 32;

    // dir=0 rotates toward MSB (MSB wraps to bit 0); dir=1 toward LSB.
    function automatic logic [LED_MAX_W-1:0] rot1(
        input logic [LED_MAX_W-1:0] value,
        input logic                 dir,
        input int unsigned          width
    );
        logic [LED_MAX_W-1:0] mask;
        logic [LED_MAX_W-1:0] v;
        mask = {LED_MAX_W{1'b1}} >> (LED_MAX_W - width);
        v    = value & mask;
        if (dir) begin
            rot1 = ((v >> 1) | (v << (width - 1))) & mask;
        end else begin
            rot1 = ((v << 1) | (v >> (width - 1))) & mask;
        end
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Reloadable down-counter that strobes step_o once every HALF_PERIOD cycles
// while running; restart_i reloads the count and suppresses the strobe.
module led_step_timer #(
    parameter int unsigned HALF_PERIOD = 50_000_000,
    parameter int unsigned CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic run_i,
    output logic step_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign step_o = w_zero && run_i && !restart_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RELOAD;
        end else if (restart_i || (run_i && w_zero)) begin
            r_cnt <= RELOAD;
        end else if (run_i) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// LED driver with OFF/BLINK/SOLID/CHASE modes; owns all LED timing and
// emits a one-cycle tick_o on every BLINK/CHASE step.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 4,
    parameter int unsigned HALF_PERIOD = 50_000_000,
    parameter int unsigned CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode_i,
    input  logic [NUM_LEDS-1:0] pattern_i,
    input  logic                dir_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                tick_o
);

    logic [1:0]          r_mode;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_tick;

    logic                w_mode_chg;
    logic                w_run;
    logic                w_step;
    logic [NUM_LEDS-1:0] w_rot;
    logic [NUM_LEDS-1:0] w_chase_entry;

    assign w_mode_chg    = (mode_i != r_mode);
    assign w_run         = (r_mode == MODE_BLINK) || (r_mode == MODE_CHASE);
    assign w_rot         = NUM_LEDS'(rot1(LED_MAX_W'(r_leds), dir_i, NUM_LEDS));
    assign w_chase_entry = dir_i ? {1'b1, {(NUM_LEDS-1){1'b0}}} : NUM_LEDS'(1);

    // A mode change reloads the timer and masks any coincident step.
    led_step_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (w_mode_chg),
        .run_i     (w_run),
        .step_o    (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_OFF;
            r_leds <= '0;
            r_tick <= 1'b0;
        end else if (w_mode_chg) begin
            r_mode <= mode_i;
            r_tick <= 1'b0;
            case (mode_i)
                MODE_OFF:   r_leds <= '0;
                MODE_BLINK: r_leds <= '1;
                MODE_SOLID: r_leds <= pattern_i;
                default:    r_leds <= w_chase_entry;
            endcase
        end else begin
            r_tick <= w_step;
            case (r_mode)
                MODE_OFF:   r_leds <= '0;
                MODE_SOLID: r_leds <= pattern_i;
                MODE_BLINK: if (w_step) r_leds <= ~r_leds;
                default:    if (w_step) r_leds <= w_rot;
            endcase
        end
    end

    assign leds_o = r_leds;
    assign tick_o = r_tick;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver (NUM_LEDS=4, HALF_PERIOD=4):
// a per-cycle vector table plus hand-written chase/reset sequences.
module tb_led_pattern_driver;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_BLINK = 2'd1;
    localparam logic [1:0] M_SOLID = 2'd2;
    localparam logic [1:0] M_CHASE = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode_i;
    logic [3:0] pattern_i;
    logic       dir_i;
    logic [3:0] leds_o;
    logic       tick_o;

    int total;
    int bad;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] pat;
        logic       dir;
        logic [3:0] leds;
        logic       tick;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    led_pattern_driver #(
        .NUM_LEDS    (4),
        .HALF_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_i    (mode_i),
        .pattern_i (pattern_i),
        .dir_i     (dir_i),
        .leds_o    (leds_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] exp_leds, input logic exp_tick);
        total = total + 1;
        if (leds_o !== exp_leds || tick_o !== exp_tick) begin
            bad = bad + 1;
            $display("FAIL %s: leds_o=%b tick_o=%b, required leds_o=%b tick_o=%b",
                     nm, leds_o, tick_o, exp_leds, exp_tick);
        end
    endtask

    function automatic void add(input int n, input logic [1:0] mode, input logic [3:0] pat,
                                input logic dir, input logic [3:0] leds, input logic tick,
                                input string nm);
        vec_t v;
        v.mode = mode; v.pat = pat; v.dir = dir; v.leds = leds; v.tick = tick; v.nm = nm;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    // One clock with the currently driven inputs, then check.
    task automatic cyc(input logic [3:0] exp_leds, input logic exp_tick, input string nm);
        @(posedge clk);
        #1;
        chk(nm, exp_leds, exp_tick);
    endtask

    // Three quiet cycles holding prev, then the step to next with tick.
    task automatic step(input logic [3:0] prev, input logic [3:0] next, input string nm);
        for (int i = 0; i < 3; i++) cyc(prev, 1'b0, {nm, "_hold"});
        cyc(next, 1'b1, nm);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        mode_i    = M_OFF;
        pattern_i = 4'b0000;
        dir_i     = 1'b0;

        #12;
        chk("reset_state", 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        add(20, M_OFF,   4'b0000, 1'b0, 4'b0000, 1'b0, "off_hold");
        add(1,  M_BLINK, 4'b0000, 1'b0, 4'b1111, 1'b0, "blink_entry");
        add(3,  M_BLINK, 4'b0000, 1'b0, 4'b1111, 1'b0, "blink_wait1");
        add(1,  M_BLINK, 4'b0000, 1'b0, 4'b0000, 1'b1, "blink_step5");
        add(3,  M_BLINK, 4'b0000, 1'b0, 4'b0000, 1'b0, "blink_wait2");
        add(1,  M_BLINK, 4'b0000, 1'b0, 4'b1111, 1'b1, "blink_step9");
        add(3,  M_BLINK, 4'b0000, 1'b0, 4'b1111, 1'b0, "blink_wait3");
        add(1,  M_SOLID, 4'b1010, 1'b0, 4'b1010, 1'b0, "solid_entry_at_zero");
        add(2,  M_SOLID, 4'b1010, 1'b0, 4'b1010, 1'b0, "solid_hold");
        add(3,  M_SOLID, 4'b0110, 1'b0, 4'b0110, 1'b0, "solid_follow");
        add(1,  M_SOLID, 4'b0001, 1'b0, 4'b0001, 1'b0, "solid_follow2");
        add(3,  M_OFF,   4'b1111, 1'b0, 4'b0000, 1'b0, "off_again");

        foreach (tbl[i]) begin
            mode_i    = tbl[i].mode;
            pattern_i = tbl[i].pat;
            dir_i     = tbl[i].dir;
            @(posedge clk);
            #1;
            chk(tbl[i].nm, tbl[i].leds, tbl[i].tick);
        end

        mode_i    = M_CHASE;
        pattern_i = 4'b0000;
        dir_i     = 1'b0;
        cyc(4'b0001, 1'b0, "chase_entry");
        step(4'b0001, 4'b0010, "chase_l1");
        step(4'b0010, 4'b0100, "chase_l2");
        step(4'b0100, 4'b1000, "chase_l3");
        step(4'b1000, 4'b0001, "chase_wrap_l");
        step(4'b0001, 4'b0010, "chase_l4");
        step(4'b0010, 4'b0100, "chase_l5");
        dir_i = 1'b1;
        step(4'b0100, 4'b0010, "chase_r1");
        step(4'b0010, 4'b0001, "chase_r2");
        step(4'b0001, 4'b1000, "chase_wrap_r");

        // Leave BLINK on the cycle its counter sits at zero.
        mode_i = M_BLINK;
        cyc(4'b1111, 1'b0, "blink_reentry");
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, "blink_count");
        mode_i = M_CHASE;
        dir_i  = 1'b0;
        cyc(4'b0001, 1'b0, "chg_at_zero");
        step(4'b0001, 4'b0010, "after_chg");
        step(4'b0010, 4'b0100, "before_reset");

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 1'b0);
        mode_i = M_OFF;
        @(posedge clk);
        #1;
        chk("in_reset", 4'b0000, 1'b0);
        rst_n  = 1'b1;
        mode_i = M_CHASE;
        cyc(4'b0001, 1'b0, "post_reset_entry");
        step(4'b0001, 4'b0010, "post_reset_step");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
